// File: rtl/step_position_tracker_if.sv
// Bundle of the step-tracker control/status signals between the move controller and the tracker.
// master drives step clock and move requests; slave is the tracker itself.
interface step_position_tracker_if #(
    parameter int POS_W = 32
);
    logic             step_clk;
    logic             start;
    logic             abort;
    logic [POS_W-1:0] target;

    logic             gen_en;
    logic [3:0]       phase;
    logic [POS_W-1:0] position;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    // start is a single-cycle request accepted only while idle; done is a single-cycle
    // completion pulse; gen_en is a level that asks the generator for step_clk edges.
    modport master (
        output step_clk, start, abort, target,
        input  gen_en, phase, position, busy, done, dbg_state
    );

    modport slave (
        input  step_clk, start, abort, target,
        output gen_en, phase, position, busy, done, dbg_state
    );
endinterface

// File: rtl/step_position_tracker.sv
// Counts step_clk rising edges into a signed position, sequences stepper coil phases and runs a move FSM.
// Define STEP_HALF_EN for the 8-entry half-step table; otherwise a 4-entry full-step two-coil table is used.
module step_position_tracker #(
    parameter int POS_W      = 32,
    parameter int SETTLE_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    step_position_tracker_if.slave  bus
);

`ifdef STEP_HALF_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             step_q;
    logic             step_edge;
    logic             take_step;
    logic             start_ok;
    logic             dir_up;
    logic             hit_tgt;
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] position;
    logic [POS_W-1:0] pos_next;
    logic [POS_W-1:0] tgt;
    logic [CNT_W-1:0] settle_cnt;

    function automatic logic [3:0] phase_lut(input logic [IDX_W-1:0] i);
        logic [3:0] p;
        p = 4'b0000;
`ifdef STEP_HALF_EN
        case (i)
            3'd0: p = 4'b0001;
            3'd1: p = 4'b0011;
            3'd2: p = 4'b0010;
            3'd3: p = 4'b0110;
            3'd4: p = 4'b0100;
            3'd5: p = 4'b1100;
            3'd6: p = 4'b1000;
            3'd7: p = 4'b1001;
        endcase
`else
        case (i)
            2'd0: p = 4'b0011;
            2'd1: p = 4'b0110;
            2'd2: p = 4'b1100;
            2'd3: p = 4'b1001;
        endcase
`endif
        return p;
    endfunction

    // step_clk is launched on the opposite clock edge, so it is already stable here.
    assign step_edge = bus.step_clk & ~step_q;
    assign take_step = (state == S_RUN) && step_edge && !bus.abort;
    assign start_ok  = (state == S_IDLE) && bus.start && !bus.abort;
    assign pos_next  = dir_up ? (position + 1'b1) : (position - 1'b1);
    assign hit_tgt   = (pos_next == tgt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = (bus.target == position) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (take_step && hit_tgt) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if ((SETTLE_CYC == 0) || (settle_cnt == CNT_LAST)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        bus.gen_en    = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.dbg_state = state;
        case (state)
            S_RUN: begin
                bus.gen_en = 1'b1;
                bus.busy   = 1'b1;
            end
            S_SETTLE: begin
                bus.busy = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Coils hold the pattern of the last index even when idle.
    always_comb begin
        bus.phase    = phase_lut(idx);
        bus.position = position;
    end

    // Odometry, target latch and step edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= 1'b0;
            position <= '0;
            idx      <= '0;
            tgt      <= '0;
            dir_up   <= 1'b0;
        end else begin
            step_q <= bus.step_clk;
            if (start_ok) begin
                tgt    <= bus.target;
                dir_up <= ($signed(bus.target) > $signed(position));
            end
            if (take_step) begin
                position <= pos_next;
                idx      <= dir_up ? (idx + 1'b1) : (idx - 1'b1);
            end
        end
    end

    // Settle hold counter; restarts from zero on every entry to SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state == S_SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

endmodule
